// File: rtl/merge_run_sequencer.sv
// Splits a stream of sorted runs into alternating A/B runs for a two-input merger,
// closing each run with an all-zero terminator tuple and pulsing o_done after the last pair.
module merge_run_sequencer #(
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [LEN_WIDTH-1:0]      i_run_len,
  input  logic [LEN_WIDTH-1:0]      i_num_pairs,
  input  logic [2*DATA_WIDTH-1:0]   i_data,
  input  logic                      i_data_empty,
  output logic                      o_data_read,
  output logic [2*DATA_WIDTH-1:0]   o_fifo_1_data,
  output logic                      o_fifo_1_write,
  input  logic                      i_fifo_1_full,
  output logic [2*DATA_WIDTH-1:0]   o_fifo_2_data,
  output logic                      o_fifo_2_write,
  input  logic                      i_fifo_2_full,
  output logic                      o_busy,
  output logic                      o_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN_A  = 3'd1,
    TERM_A = 3'd2,
    RUN_B  = 3'd3,
    TERM_B = 3'd4
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] tuple_q, tuple_d;
  logic [LEN_WIDTH-1:0] pair_q, pair_d;
  logic [LEN_WIDTH-1:0] run_len_q, run_len_d;
  logic [LEN_WIDTH-1:0] num_pairs_q, num_pairs_d;
  logic [LEN_WIDTH-1:0] tuple_inc_s;
  logic [LEN_WIDTH-1:0] pair_inc_s;

  // Incremented counts never wrap: equality with the latched limit is hit first.
  assign tuple_inc_s = tuple_q + LEN_ONE;
  assign pair_inc_s  = pair_q + LEN_ONE;

  // Next-state logic and zero-latency transfer strobes, all decoded from the state register.
  always_comb begin
    state_d        = state_q;
    tuple_d        = tuple_q;
    pair_d         = pair_q;
    run_len_d      = run_len_q;
    num_pairs_d    = num_pairs_q;
    o_data_read    = 1'b0;
    o_fifo_1_write = 1'b0;
    o_fifo_1_data  = '0;
    o_fifo_2_write = 1'b0;
    o_fifo_2_data  = '0;
    o_done         = 1'b0;
    o_busy         = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (i_start && (i_run_len != '0) && (i_num_pairs != '0)) begin
          run_len_d   = i_run_len;
          num_pairs_d = i_num_pairs;
          tuple_d     = '0;
          pair_d      = '0;
          state_d     = RUN_A;
        end else begin
          state_d = IDLE;
        end
      end
      RUN_A: begin
        if (!i_data_empty && !i_fifo_1_full) begin
          o_data_read    = 1'b1;
          o_fifo_1_write = 1'b1;
          o_fifo_1_data  = i_data;
          if (tuple_inc_s == run_len_q) begin
            tuple_d = '0;
            state_d = TERM_A;
          end else begin
            tuple_d = tuple_inc_s;
          end
        end else begin
          state_d = RUN_A;
        end
      end
      TERM_A: begin
        if (!i_fifo_1_full) begin
          o_fifo_1_write = 1'b1;
          state_d        = RUN_B;
        end else begin
          state_d = TERM_A;
        end
      end
      RUN_B: begin
        if (!i_data_empty && !i_fifo_2_full) begin
          o_data_read    = 1'b1;
          o_fifo_2_write = 1'b1;
          o_fifo_2_data  = i_data;
          if (tuple_inc_s == run_len_q) begin
            tuple_d = '0;
            state_d = TERM_B;
          end else begin
            tuple_d = tuple_inc_s;
          end
        end else begin
          state_d = RUN_B;
        end
      end
      TERM_B: begin
        if (!i_fifo_2_full) begin
          o_fifo_2_write = 1'b1;
          pair_d         = pair_inc_s;
          if (pair_inc_s == num_pairs_q) begin
            o_done  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RUN_A;
          end
        end else begin
          state_d = TERM_B;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and latched job parameters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      tuple_q     <= '0;
      pair_q      <= '0;
      run_len_q   <= '0;
      num_pairs_q <= '0;
    end else begin
      state_q     <= state_d;
      tuple_q     <= tuple_d;
      pair_q      <= pair_d;
      run_len_q   <= run_len_d;
      num_pairs_q <= num_pairs_d;
    end
  end

endmodule
